// File: rtl/mul_rs.sv
// rtl/mul_rs.sv - multiply reservation station and execution unit
// Holds UMUL/SMUL(cc) ops until operands resolve via CDB, issues one product per cycle.
module mul_rs #(
   parameter int         NUM_ENTRIES = 4,
   parameter logic [4:0] TAG_BASE    = 5'd8,
   parameter logic [4:0] INVALID_TAG = 5'b11111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_rs_enable,
   input  logic [4:0]  in_operator_type,
   input  logic [31:0] in_val_1,
   input  logic [31:0] in_val_2,
   input  logic [4:0]  in_tag_1,
   input  logic [4:0]  in_tag_2,
   input  logic        in_CDB_broadcast,
   input  logic [4:0]  in_CDB_tag,
   input  logic [31:0] in_CDB_val,
   input  logic [31:0] in_Y_val,
   output logic        out_rs_enable,
   output logic [4:0]  out_rs_tag,
   output logic        out_CDB_broadcast,
   output logic [4:0]  out_CDB_tag,
   output logic [31:0] out_CDB_val,
   output logic [31:0] out_Y_val,
   output logic [3:0]  out_ICC_flags
);

   localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   logic [NUM_ENTRIES-1:0] r_busy;
   logic [4:0]             r_op   [NUM_ENTRIES];
   logic [31:0]            r_val1 [NUM_ENTRIES];
   logic [4:0]             r_tag1 [NUM_ENTRIES];
   logic [31:0]            r_val2 [NUM_ENTRIES];
   logic [4:0]             r_tag2 [NUM_ENTRIES];

   logic        r_out_bcast;
   logic [4:0]  r_out_tag;
   logic [31:0] r_out_val;
   logic [31:0] r_out_y;
   logic [3:0]  r_out_flags;

   logic          w_any_free;
   logic [IW-1:0] w_free_idx;
   logic          w_any_ready;
   logic [IW-1:0] w_iss_idx;
   logic [4:0]    w_iss_op;
   logic [63:0]   w_ext_a;
   logic [63:0]   w_ext_b;
   logic [63:0]   w_prod;
   logic          w_supported;
   logic [31:0]   w_in_val1;
   logic [4:0]    w_in_tag1;
   logic [31:0]   w_in_val2;
   logic [4:0]    w_in_tag2;

   // Descending scan so the lowest index wins for both free and ready selection.
   always_comb begin
      w_any_free  = 1'b0;
      w_free_idx  = '0;
      w_any_ready = 1'b0;
      w_iss_idx   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            w_any_free = 1'b1;
            w_free_idx = IW'(i);
         end
         if (r_busy[i] && r_tag1[i] == INVALID_TAG && r_tag2[i] == INVALID_TAG) begin
            w_any_ready = 1'b1;
            w_iss_idx   = IW'(i);
         end
      end
   end

   assign out_rs_enable = w_any_free;
   assign out_rs_tag    = w_any_free ? TAG_BASE + 5'(w_free_idx) : INVALID_TAG;

   // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
   assign w_iss_op    = r_op[w_iss_idx];
   assign w_ext_a     = w_iss_op[0] ? {{32{r_val1[w_iss_idx][31]}}, r_val1[w_iss_idx]}
                                    : {32'b0, r_val1[w_iss_idx]};
   assign w_ext_b     = w_iss_op[0] ? {{32{r_val2[w_iss_idx][31]}}, r_val2[w_iss_idx]}
                                    : {32'b0, r_val2[w_iss_idx]};
   assign w_prod      = w_ext_a * w_ext_b;
   assign w_supported = (w_iss_op[3:1] == 3'b101);

   assign w_in_val1 = (in_CDB_broadcast && in_tag_1 != INVALID_TAG && in_tag_1 == in_CDB_tag)
                      ? in_CDB_val : in_val_1;
   assign w_in_tag1 = (in_CDB_broadcast && in_tag_1 == in_CDB_tag) ? INVALID_TAG : in_tag_1;
   assign w_in_val2 = (in_CDB_broadcast && in_tag_2 != INVALID_TAG && in_tag_2 == in_CDB_tag)
                      ? in_CDB_val : in_val_2;
   assign w_in_tag2 = (in_CDB_broadcast && in_tag_2 == in_CDB_tag) ? INVALID_TAG : in_tag_2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy      <= '0;
         r_out_bcast <= 1'b0;
         r_out_tag   <= INVALID_TAG;
         r_out_val   <= '0;
         r_out_y     <= '0;
         r_out_flags <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_op[i]   <= '0;
            r_val1[i] <= '0;
            r_tag1[i] <= INVALID_TAG;
            r_val2[i] <= '0;
            r_tag2[i] <= INVALID_TAG;
         end
      end else begin
         r_out_bcast <= w_any_ready;
         if (w_any_ready) begin
            r_out_tag <= TAG_BASE + 5'(w_iss_idx);
            if (w_supported) begin
               r_out_val   <= w_prod[31:0];
               r_out_y     <= w_prod[63:32];
               r_out_flags <= w_iss_op[4] ? {w_prod[31], (w_prod[31:0] == 32'd0), 2'b00} : 4'b0000;
            end else begin
               r_out_val   <= '0;
               r_out_y     <= in_Y_val;
               r_out_flags <= 4'b0000;
            end
         end
         // Issue and allocation are disjoint: a ready entry is busy, an allocated one is free.
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_any_ready && w_iss_idx == IW'(i)) begin
               r_busy[i] <= 1'b0;
            end else if (in_rs_enable && w_any_free && w_free_idx == IW'(i)) begin
               r_busy[i] <= 1'b1;
               r_op[i]   <= in_operator_type;
               r_val1[i] <= w_in_val1;
               r_tag1[i] <= w_in_tag1;
               r_val2[i] <= w_in_val2;
               r_tag2[i] <= w_in_tag2;
            end else if (r_busy[i] && in_CDB_broadcast) begin
               if (r_tag1[i] != INVALID_TAG && r_tag1[i] == in_CDB_tag) begin
                  r_val1[i] <= in_CDB_val;
                  r_tag1[i] <= INVALID_TAG;
               end
               if (r_tag2[i] != INVALID_TAG && r_tag2[i] == in_CDB_tag) begin
                  r_val2[i] <= in_CDB_val;
                  r_tag2[i] <= INVALID_TAG;
               end
            end
         end
      end
   end

   assign out_CDB_broadcast = r_out_bcast;
   assign out_CDB_tag       = r_out_tag;
   assign out_CDB_val       = r_out_val;
   assign out_Y_val         = r_out_y;
   assign out_ICC_flags     = r_out_flags;

endmodule

// File: tb/tb_mul_rs.sv
// tb/tb_mul_rs.sv - scoreboard bench for mul_rs
// Stimulus pushes expected results; a negedge monitor pops and compares each broadcast.
module tb_mul_rs;

   localparam logic [4:0] INV = 5'b11111;
   localparam logic [4:0] OP_UMUL   = 5'b01010;
   localparam logic [4:0] OP_SMUL   = 5'b01011;
   localparam logic [4:0] OP_UMULCC = 5'b11010;
   localparam logic [4:0] OP_SMULCC = 5'b11011;

   logic        clk;
   logic        reset;
   logic        in_rs_enable;
   logic [4:0]  in_operator_type;
   logic [31:0] in_val_1;
   logic [31:0] in_val_2;
   logic [4:0]  in_tag_1;
   logic [4:0]  in_tag_2;
   logic        in_CDB_broadcast;
   logic [4:0]  in_CDB_tag;
   logic [31:0] in_CDB_val;
   logic [31:0] in_Y_val;
   logic        out_rs_enable;
   logic [4:0]  out_rs_tag;
   logic        out_CDB_broadcast;
   logic [4:0]  out_CDB_tag;
   logic [31:0] out_CDB_val;
   logic [31:0] out_Y_val;
   logic [3:0]  out_ICC_flags;

   mul_rs dut (
      .clk               (clk),
      .reset             (reset),
      .in_rs_enable      (in_rs_enable),
      .in_operator_type  (in_operator_type),
      .in_val_1          (in_val_1),
      .in_val_2          (in_val_2),
      .in_tag_1          (in_tag_1),
      .in_tag_2          (in_tag_2),
      .in_CDB_broadcast  (in_CDB_broadcast),
      .in_CDB_tag        (in_CDB_tag),
      .in_CDB_val        (in_CDB_val),
      .in_Y_val          (in_Y_val),
      .out_rs_enable     (out_rs_enable),
      .out_rs_tag        (out_rs_tag),
      .out_CDB_broadcast (out_CDB_broadcast),
      .out_CDB_tag       (out_CDB_tag),
      .out_CDB_val       (out_CDB_val),
      .out_Y_val         (out_Y_val),
      .out_ICC_flags     (out_ICC_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  tag;
      logic [31:0] val;
      logic [31:0] y;
      logic [3:0]  flags;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   bcast_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_res(input logic [4:0] t, input logic [31:0] v, input logic [31:0] y,
                             input logic [3:0] f);
      exp_t e;
      e.tag = t; e.val = v; e.y = y; e.flags = f;
      exp_q.push_back(e);
   endtask

   // Monitor: every broadcast must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && out_CDB_broadcast) begin
         bcast_count++;
         if (exp_q.size() == 0) begin
            check("unexpected_broadcast", {59'd0, out_CDB_tag}, {59'd0, INV});
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("cdb_tag",   {59'd0, out_CDB_tag},   {59'd0, e.tag});
            check("cdb_val",   {32'd0, out_CDB_val},   {32'd0, e.val});
            check("y_val",     {32'd0, out_Y_val},     {32'd0, e.y});
            check("icc_flags", {60'd0, out_ICC_flags}, {60'd0, e.flags});
         end
      end
   end

   task automatic alloc(input logic [4:0] op, input logic [31:0] v1, input logic [4:0] t1,
                        input logic [31:0] v2, input logic [4:0] t2);
      in_rs_enable = 1'b1; in_operator_type = op;
      in_val_1 = v1; in_tag_1 = t1; in_val_2 = v2; in_tag_2 = t2;
      @(posedge clk); #1;
      in_rs_enable = 1'b0;
   endtask

   task automatic cdb(input logic [4:0] t, input logic [31:0] v);
      in_CDB_broadcast = 1'b1; in_CDB_tag = t; in_CDB_val = v;
      @(posedge clk); #1;
      in_CDB_broadcast = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
         @(negedge clk); #1;
      end
      check(name, {32'd0, 32'(exp_q.size())}, 64'd0);
   endtask

   int snap;

   initial begin
      reset = 1'b1; in_rs_enable = 1'b0; in_operator_type = '0;
      in_val_1 = '0; in_val_2 = '0; in_tag_1 = INV; in_tag_2 = INV;
      in_CDB_broadcast = 1'b0; in_CDB_tag = '0; in_CDB_val = '0; in_Y_val = 32'h12345678;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rs_enable", {63'd0, out_rs_enable}, 64'd1);
      check("rst_rs_tag",    {59'd0, out_rs_tag},    64'd8);
      check("rst_bcast",     {63'd0, out_CDB_broadcast}, 64'd0);
      check("rst_cdb_tag",   {59'd0, out_CDB_tag},   {59'd0, INV});
      reset = 1'b0;
      @(posedge clk); #1;

      // Both operands ready at dispatch.
      expect_res(5'd8, 32'd6, 32'd0, 4'b0000);
      alloc(OP_UMUL, 32'd2, INV, 32'd3, INV);
      check("t1_rs_enable", {63'd0, out_rs_enable}, 64'd1);
      check("t1_rs_tag",    {59'd0, out_rs_tag},    64'd9);
      drain("t1_drain");

      // One operand arrives on the CDB one edge after dispatch.
      expect_res(5'd8, 32'd4, 32'd0, 4'b0000);
      alloc(OP_UMUL, 32'd4, INV, 32'd0, 5'd3);
      cdb(5'd3, 32'd1);
      check("t2_no_early_bcast", {63'd0, out_CDB_broadcast}, 64'd0);
      @(posedge clk); #1;
      check("t2_bcast_latency", {63'd0, out_CDB_broadcast}, 64'd1);
      drain("t2_drain");

      // Two captures separated by an idle cycle; a single broadcast after the second.
      snap = bcast_count;
      expect_res(5'd8, 32'd42, 32'd0, 4'b0000);
      alloc(OP_UMUL, 32'd0, 5'd2, 32'd0, 5'd3);
      cdb(5'd2, 32'd7);
      @(posedge clk); #1;
      cdb(5'd3, 32'd6);
      check("t3_no_early_bcast", {63'd0, out_CDB_broadcast}, 64'd0);
      check("t3_no_early_count", {32'd0, 32'(bcast_count)}, {32'd0, 32'(snap)});
      @(posedge clk); #1;
      check("t3_bcast_latency", {63'd0, out_CDB_broadcast}, 64'd1);
      drain("t3_drain");

      // Arithmetic corners, back-to-back dispatch.
      expect_res(5'd8, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000);
      alloc(OP_SMULCC, 32'hFFFFFFFE, INV, 32'd3, INV);
      drain("t4_drain");
      expect_res(5'd8, 32'hFFFFFFFE, 32'd1, 4'b0000);
      expect_res(5'd9, 32'd0, 32'd0, 4'b0100);
      alloc(OP_UMUL, 32'hFFFFFFFF, INV, 32'd2, INV);
      alloc(OP_UMULCC, 32'd0, INV, 32'd5, INV);
      drain("t5_drain");
      expect_res(5'd8, 32'd1, 32'd0, 4'b0000);
      expect_res(5'd9, 32'd0, 32'h40000000, 4'b0000);
      expect_res(5'd8, 32'd0, 32'h12345678, 4'b0000);
      alloc(OP_SMUL, 32'hFFFFFFFF, INV, 32'hFFFFFFFF, INV);
      alloc(OP_SMUL, 32'h80000000, INV, 32'h80000000, INV);
      alloc(5'b00000, 32'd9, INV, 32'd9, INV);
      drain("t6_drain");

      // Fill the station, overflow request ignored, then free one entry.
      for (int i = 0; i < 4; i++) alloc(OP_UMUL, 32'd0, 5'(i + 1), 32'd10, INV);
      check("full_rs_enable", {63'd0, out_rs_enable}, 64'd0);
      check("full_rs_tag",    {59'd0, out_rs_tag},    {59'd0, INV});
      snap = bcast_count;
      alloc(OP_UMUL, 32'd1, INV, 32'd1, INV);
      repeat (3) @(posedge clk);
      #1;
      check("full_ignored", {32'd0, 32'(bcast_count)}, {32'd0, 32'(snap)});
      expect_res(5'd9, 32'd50, 32'd0, 4'b0000);
      cdb(5'd2, 32'd5);
      @(posedge clk); #1;
      check("freed_bcast",     {63'd0, out_CDB_broadcast}, 64'd1);
      check("freed_rs_enable", {63'd0, out_rs_enable}, 64'd1);
      check("freed_rs_tag",    {59'd0, out_rs_tag},    64'd9);
      drain("t7_drain");

      // Asynchronous reset while entries 0, 2, 3 are still waiting.
      #2 reset = 1'b1;
      #1;
      check("arst_rs_enable", {63'd0, out_rs_enable}, 64'd1);
      check("arst_rs_tag",    {59'd0, out_rs_tag},    64'd8);
      check("arst_cdb_tag",   {59'd0, out_CDB_tag},   {59'd0, INV});
      check("arst_cdb_val",   {32'd0, out_CDB_val},   64'd0);
      check("arst_flags",     {60'd0, out_ICC_flags}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      snap = bcast_count;
      cdb(5'd1, 32'd3);
      cdb(5'd3, 32'd3);
      repeat (2) @(posedge clk);
      #1;
      check("arst_discard", {32'd0, 32'(bcast_count)}, {32'd0, 32'(snap)});

      expect_res(5'd8, 32'd6, 32'd0, 4'b0000);
      alloc(OP_UMUL, 32'd2, INV, 32'd3, INV);
      drain("t8_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_rs.md
Name: mul_rs

Overview:
- Multiply reservation station and execution unit for the Tomasulo out-of-order SPARC core.
- Accepts UMUL/SMUL/UMULcc/SMULcc operations from rename/dispatch and holds them until both operands are available, capturing operands from the common data bus (CDB) as they arrive.
- Executes one multiply per cycle and broadcasts the low word, the Y (high word) value and the ICC flags on its CDB output.

Parameters:
- NUM_ENTRIES, 4: number of station entries.
- TAG_BASE, 5'd8: tag of entry 0; entry i has tag TAG_BASE+i.
- INVALID_TAG, 5'b11111: tag value meaning "operand value is ready".

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_rs_enable  in  1  allocate an entry on this edge.
- in_operator_type  in  5  low 5 bits of SPARC op3: 01010 UMUL, 01011 SMUL, 11010 UMULcc, 11011 SMULcc.
- in_val_1, in_val_2  in  32  operand values; valid when the matching tag is INVALID_TAG.
- in_tag_1, in_tag_2  in  5  producer tags; INVALID_TAG means the value is ready.
- in_CDB_broadcast  in  1  CDB valid.
- in_CDB_tag  in  5  CDB producer tag.
- in_CDB_val  in  32  CDB value.
- in_Y_val  in  32  current Y register; forwarded only for unsupported opcodes.
- out_rs_enable  out  1  1 when at least one entry is free (can accept).
- out_rs_tag  out  5  tag of the entry the next allocation will use; INVALID_TAG when full.
- out_CDB_broadcast  out  1  result valid, one-cycle pulse per result.
- out_CDB_tag  out  5  tag of the completing entry.
- out_CDB_val  out  32  product[31:0].
- out_Y_val  out  32  product[63:32].
- out_ICC_flags  out  4  {N,Z,V,C}.

Behaviour:
- Reset: all entries free. out_rs_enable=1, out_rs_tag=TAG_BASE, out_CDB_broadcast=0, out_CDB_tag=INVALID_TAG, out_CDB_val=0, out_Y_val=0, out_ICC_flags=0.
- Entry state: busy, op, val1, tag1, val2, tag2.
- out_rs_enable and out_rs_tag are combinational from the free state. The lowest-index free entry is chosen.
- Allocation: at a rising edge with in_rs_enable=1 and a free entry, the chosen entry loads op, values and tags. With no free entry, the request is ignored.
- CDB snoop: at each edge with in_CDB_broadcast=1, every busy entry whose tagN equals in_CDB_tag (and is not INVALID_TAG) loads valN=in_CDB_val and sets tagN=INVALID_TAG.
- Allocation bypass: if an incoming tag equals in_CDB_tag on the same edge with broadcast=1, the entry stores the CDB value with tag INVALID_TAG.
- Ready: entry is busy and both tags are INVALID_TAG, evaluated on pre-edge state. An operand captured at edge k makes the entry ready for edge k+1.
- Issue/complete: at each edge, the lowest-index ready entry is multiplied. Its result is registered on that edge and the entry is freed. Latency is ready -> broadcast visible after the next edge.
  - out_CDB_broadcast=1 for exactly one cycle, unless another entry completes on the next edge.
  - With no ready entry, out_CDB_broadcast=0; the other outputs hold their last values.
- Arithmetic:
  - UMUL(cc): unsigned 32x32->64.
  - SMUL(cc): two's-complement signed 32x32->64.
  - cc ops: N=product[31], Z=(product[31:0]==0), V=0, C=0.
  - Non-cc ops: out_ICC_flags=0000.
- Unsupported opcode: out_CDB_val=0, out_Y_val=in_Y_val, flags 0, still broadcast with its tag (no deadlock).
- Simultaneous events:
  - A freed entry is not reallocated on the same edge; allocation uses pre-edge free state.
  - A snoop and a completion on the same edge are independent.
  - A station's own broadcast looped back to in_CDB_* wakes dependents like any other producer.
- Reset mid-operation clears all entries and outputs immediately (asynchronous); in-flight results are discarded.

Test Plan:
- Reset, then UMUL (op 01010), tags 31/31, vals 2,3 -> broadcast tag 8, val 6, Y 0, flags 0000; out_rs_enable stays 1.
- UMUL, val1=4, tag2=3, then CDB tag 3 val 1 on the next edge -> no broadcast before capture; then broadcast val 4, Y 0.
- UMUL, tags 2/3; CDB tag 2 val 7, one idle cycle, then CDB tag 3 val 6 -> single broadcast val 42 after the second capture.
- SMULcc (11011), -2 x 3 -> val 0xFFFFFFFA, Y 0xFFFFFFFF, flags 1000.
- UMUL 0xFFFFFFFF x 2 -> val 0xFFFFFFFE, Y 1. UMULcc 0 x 5 -> flags 0100.
- Fill all 4 entries with unresolved tags -> out_rs_enable=0, out_rs_tag=31, a 5th request is ignored. Resolve one -> it broadcasts, then out_rs_enable=1 with that entry's tag. Assert reset mid-fill -> all outputs return to reset values immediately.
